// File: rtl/fifo_frame_reader.sv
// Drains one FRAME_LEN-word frame from the sample FIFO and emits it as a framed byte
// stream (sync, seq, len, payload, checksum) with a valid/ready handshake.
module fifo_frame_reader #(
    parameter int              WBITS      = 8,
    parameter int              FRAME_LEN  = 32,
    parameter logic [7:0]      SYNC0      = 8'hAA,
    parameter logic [7:0]      SYNC1      = 8'h55,
    parameter int              GAP_CYCLES = 4
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [15:0]      fifo_cnt,
    input  logic             fifo_empty,
    input  logic [WBITS-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [WBITS-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [15:0]      frame_cnt,
    output logic             underrun,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for enable and a full frame in the FIFO
    // HDR0  | sending SYNC0
    // HDR1  | sending SYNC1
    // SEQ   | sending sequence number
    // LEN   | sending FRAME_LEN
    // REQ   | issuing one FIFO read (stalls while empty)
    // CAP   | capturing the registered FIFO word
    // PAY   | sending the captured payload byte
    // CSUM  | sending the checksum, m_last high
    // GAP   | forced idle between frames
    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_SEQ, S_LEN, S_REQ, S_CAP, S_PAY, S_CSUM, S_GAP
    } state_t;

    localparam logic [15:0]      LEN_W = FRAME_LEN[15:0];
    localparam logic [7:0]       LEN_C = FRAME_LEN[7:0];
    localparam logic [WBITS-1:0] LEN_B = FRAME_LEN[WBITS-1:0];
    localparam logic [7:0]       GAP_C = GAP_CYCLES[7:0];

    state_t           state, state_nxt;
    logic [WBITS-1:0] seq_q;
    logic [WBITS-1:0] csum_q;
    logic [WBITS-1:0] pay_q;
    logic [7:0]       byte_cnt_q;
    logic [7:0]       gap_cnt_q;
    logic [15:0]      frame_cnt_q;
    logic             underrun_q;
    logic             xfer;

    assign xfer = m_valid & m_ready;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable && (fifo_cnt >= LEN_W)) state_nxt = S_HDR0;
            S_HDR0: if (xfer) state_nxt = S_HDR1;
            S_HDR1: if (xfer) state_nxt = S_SEQ;
            S_SEQ:  if (xfer) state_nxt = S_LEN;
            S_LEN:  if (xfer) state_nxt = S_REQ;
            S_REQ:  if (!fifo_empty) state_nxt = S_CAP;
            S_CAP:  state_nxt = S_PAY;
            S_PAY:  if (xfer) state_nxt = (byte_cnt_q == 8'd1) ? S_CSUM : S_REQ;
            S_CSUM: if (xfer) state_nxt = S_GAP;
            // A zero gap count still spends one cycle here.
            S_GAP:  if (gap_cnt_q <= 8'd1) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        fifo_rd_en = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_HDR0: begin m_valid = 1'b1; m_data = SYNC0[WBITS-1:0]; end
            S_HDR1: begin m_valid = 1'b1; m_data = SYNC1[WBITS-1:0]; end
            S_SEQ:  begin m_valid = 1'b1; m_data = seq_q; end
            S_LEN:  begin m_valid = 1'b1; m_data = LEN_B; end
            S_REQ:  fifo_rd_en = ~fifo_empty;
            S_PAY:  begin m_valid = 1'b1; m_data = pay_q; end
            S_CSUM: begin m_valid = 1'b1; m_data = csum_q; m_last = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            seq_q       <= '0;
            csum_q      <= '0;
            pay_q       <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            case (state)
                S_SEQ: if (xfer) csum_q <= seq_q;
                S_LEN: if (xfer) begin
                    csum_q     <= csum_q + LEN_B;
                    byte_cnt_q <= LEN_C;
                end
                S_REQ: if (fifo_empty) underrun_q <= 1'b1;
                S_CAP: pay_q <= fifo_dout;
                S_PAY: if (xfer) begin
                    csum_q     <= csum_q + pay_q;
                    byte_cnt_q <= byte_cnt_q - 8'd1;
                end
                S_CSUM: if (xfer) begin
                    seq_q       <= seq_q + 1'b1;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    gap_cnt_q   <= GAP_C;
                end
                S_GAP: if (gap_cnt_q != 8'd0) gap_cnt_q <= gap_cnt_q - 8'd1;
                default: ;
            endcase
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: FIFO model plus a frame-level reference checked every cycle,
// directed scenarios with hand-computed expectations and random m_ready stalls.
module tb_fifo_frame_reader;

    localparam int LEN = 4;
    localparam int GAP = 4;

    logic        rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        m_ready = 1'b1;
    logic        force_empty = 1'b0;
    logic        fifo_flush = 1'b0;
    logic        rand_ready = 1'b0;
    logic [7:0]  fifo_dout = 8'h00;
    logic [7:0]  mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    wire  [15:0] fifo_cnt = 16'(wr_ptr - rd_ptr);
    wire         fifo_empty = (wr_ptr == rd_ptr) || force_empty;
    logic        fifo_rd_en, m_valid, m_last, underrun, busy;
    logic [7:0]  m_data;
    logic [15:0] frame_cnt;

    fifo_frame_reader #(.WBITS(8), .FRAME_LEN(LEN), .SYNC0(8'hAA), .SYNC1(8'h55),
                        .GAP_CYCLES(GAP)) dut (
        .rst(rst), .rd_clk(rd_clk), .enable(enable), .fifo_cnt(fifo_cnt),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frame_cnt(frame_cnt), .underrun(underrun), .busy(busy)
    );

    initial forever #5 rd_clk = ~rd_clk;

    // Registered-output FIFO read port: data the cycle after the strobe, zero otherwise.
    always @(posedge rd_clk) begin
        if (fifo_flush) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= 8'h00;
        end else if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            fifo_dout <= 8'h00;
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] m_seq = 8'h00;
    int         m_frames = 0;
    int         rd_count = 0;
    int         rd_at_start = 0;
    int         valid_cycles = 0;
    int         frame_cycles = 0;
    int         last_frame_cycles = 0;
    int         gap_idle = 0;
    bit         in_frame = 0;
    bit         after_last = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic build_frame();
        logic [7:0] sum;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(m_seq);
        exp_q.push_back(8'(LEN));
        sum = m_seq + 8'(LEN);
        for (int k = 0; k < LEN; k++) begin
            exp_q.push_back(mem[(rd_ptr + k) % 1024]);
            sum = sum + mem[(rd_ptr + k) % 1024];
        end
        exp_q.push_back(sum);
    endtask

    // Frame-level reference, evaluated on the falling edge of every cycle.
    task automatic monitor();
        logic [7:0] b;
        if (rst) begin
            exp_q.delete();
            m_seq = 8'h00;
            m_frames = 0;
            in_frame = 0;
            after_last = 0;
            prev_stall = 0;
            return;
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        if (fifo_rd_en) begin
            rd_count++;
            chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
            chk("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (!m_valid) chk("last_without_valid", 32'(m_last), 32'd0);
        if (m_valid) valid_cycles++;
        if (m_valid && !in_frame) begin
            if (after_last) chk("gap_ge_min", 32'(gap_idle >= GAP), 32'd1);
            build_frame();
            in_frame = 1;
            frame_cycles = 0;
            rd_at_start = rd_count;
        end
        if (!m_valid && !in_frame) gap_idle++;
        if (in_frame) frame_cycles++;
        if (m_valid && m_ready && in_frame) begin
            b = exp_q.pop_front();
            chk("byte", 32'(m_data), 32'(b));
            chk("m_last", 32'(m_last), 32'(exp_q.size() == 0));
            rx_q.push_back(m_data);
            if (exp_q.size() == 0) begin
                chk("reads_per_frame", 32'(rd_count - rd_at_start), 32'(LEN));
                m_seq = m_seq + 8'd1;
                m_frames++;
                last_frame_cycles = frame_cycles;
                in_frame = 0;
                after_last = 1;
                gap_idle = 0;
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic tick();
        @(negedge rd_clk);
        monitor();
        @(posedge rd_clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_flush = 1'b1;
        enable = 1'b0;
        force_empty = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        fifo_flush = 1'b0;
        rx_q.delete();
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frame_cnt != 16'(target); i++) tick();
        chk("wait_frames", 32'(frame_cnt), 32'(target));
    endtask

    task automatic wait_reads(input int base, input int n, input int budget);
        for (int i = 0; i < budget && (rd_count - base) < n; i++) tick();
        chk("wait_reads", 32'(rd_count - base >= n), 32'd1);
    endtask

    int base_rd;
    int base_v;

    initial begin
        // reset values
        tick();
        tick();
        rst = 1'b0;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // single frame, literal stream
        do_reset();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        base_rd = rd_count;
        m_ready = 1'b1;
        enable = 1'b1;
        wait_frames(1, 100);
        begin
            logic [7:0] lit [9];
            lit = '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
            chk("t1_len", 32'(rx_q.size()), 32'd9);
            for (int i = 0; i < 9 && i < rx_q.size(); i++) chk("t1_stream", 32'(rx_q[i]), 32'(lit[i]));
        end
        chk("t1_reads", 32'(rd_count - base_rd), 32'd4);
        chk("t1_frame_cycles", 32'(last_frame_cycles), 32'd17);
        for (int i = 0; i < 8; i++) tick();
        chk("t1_underrun", 32'(underrun), 32'd0);

        // below-threshold fill, then threshold reached
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        enable = 1'b1;
        base_rd = rd_count;
        base_v = valid_cycles;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_no_valid", 32'(valid_cycles - base_v), 32'd0);
        chk("t2_no_rd", 32'(rd_count - base_rd), 32'd0);
        chk("t2_idle", 32'(busy), 32'd0);
        push(8'h44);
        for (int i = 0; i < 2 && valid_cycles == base_v; i++) tick();
        chk("t2_start_latency", 32'(valid_cycles > base_v), 32'd1);
        wait_frames(1, 100);

        // three back-to-back frames with random backpressure
        do_reset();
        for (int i = 0; i < 3 * LEN; i++) push(8'($urandom_range(0, 255)));
        rand_ready = 1'b1;
        enable = 1'b1;
        wait_frames(3, 2000);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        chk("t3_frames", 32'(frame_cnt), 32'd3);
        if (rx_q.size() >= 21) begin
            chk("t3_seq0", 32'(rx_q[2]), 32'h00);
            chk("t3_seq1", 32'(rx_q[11]), 32'h01);
            chk("t3_seq2", 32'(rx_q[20]), 32'h02);
        end else chk("t3_rx_bytes", 32'(rx_q.size()), 32'd27);
        chk("t3_underrun", 32'(underrun), 32'd0);

        // FIFO starves after two payload reads
        do_reset();
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        base_rd = rd_count;
        enable = 1'b1;
        wait_reads(base_rd, 2, 100);
        force_empty = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t4_underrun", 32'(underrun), 32'd1);
        chk("t4_reads_held", 32'(rd_count - base_rd), 32'd2);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_no_valid", 32'(m_valid), 32'd0);
        force_empty = 1'b0;
        wait_frames(1, 100);
        if (rx_q.size() == 9) chk("t4_csum", 32'(rx_q[8]), 32'hA4);
        else chk("t4_rx_bytes", 32'(rx_q.size()), 32'd9);
        chk("t4_underrun_sticky", 32'(underrun), 32'd1);

        // reset during payload byte 2
        do_reset();
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        push(8'h09); push(8'h0A); push(8'h0B); push(8'h0C);
        wait_frames(0, 1);
        enable = 1'b1;
        wait_frames(1, 100);
        base_rd = rd_count;
        for (int i = 0; i < 40 && !busy; i++) tick();
        wait_reads(base_rd, 2, 100);
        enable = 1'b0;
        tick();
        chk("t5_in_pay", 32'(m_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        rx_q.delete();
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        enable = 1'b1;
        wait_frames(1, 100);
        if (rx_q.size() >= 3) chk("t5_seq_restart", 32'(rx_q[2]), 32'h00);
        else chk("t5_rx_bytes", 32'(rx_q.size()), 32'd9);

        // enable dropped mid-payload
        do_reset();
        for (int i = 0; i < 2 * LEN; i++) push(8'($urandom_range(0, 255)));
        base_rd = rd_count;
        enable = 1'b1;
        wait_reads(base_rd, 1, 100);
        enable = 1'b0;
        wait_frames(1, 100);
        base_v = valid_cycles;
        for (int i = 0; i < 30; i++) tick();
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t6_no_restart", 32'(valid_cycles - base_v), 32'd0);
        chk("t6_fifo_left", 32'(fifo_cnt), 32'(LEN));
        chk("t6_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
